// File: rtl/shared_pkg.sv
// Shared types for the N-road junction controller: lamp phase encoding and
// sensor level names.
package shared_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } phase_e;

    localparam logic CARS    = 1'b1;
    localparam logic NO_CARS = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among the non-priority roads 1..NUM_ROADS-1: the first
// requesting road strictly after rr_ptr, wrapping within 1..NUM_ROADS-1.
module rr_arbiter #(
    parameter  int NUM_ROADS = 4,
    localparam int IDX_W     = $clog2(NUM_ROADS)
) (
    input  logic [NUM_ROADS-1:1] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [IDX_W-1:0]     grant,
    output logic                 valid
);

    localparam logic [IDX_W:0] LAST_ROAD = (IDX_W+1)'(NUM_ROADS - 1);

    logic [IDX_W-1:0]     cand [1:NUM_ROADS-1];
    logic [NUM_ROADS-1:1] hit;

    // cand[o] is the road o steps after rr_ptr, folded back into 1..N-1.
    genvar gi;
    generate
        for (gi = 1; gi < NUM_ROADS; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum      = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = IDX_W'((sum > LAST_ROAD) ? (sum - LAST_ROAD) : sum);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        valid = |hit;
        grant = '0;
        for (int o = NUM_ROADS - 1; o >= 1; o--) begin
            if (hit[o]) begin
                grant = cand[o];
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_nroad.sv
// Sensor-driven N-road junction controller: road 0 has priority, roads 1..N-1
// share green round-robin. Define TRAFFIC_PED_EN to add the pedestrian all-red phase.
module traffic_ctrl_nroad
    import shared_pkg::*;
#(
    parameter  int NUM_ROADS  = 4,
    parameter  int GREEN_MIN  = 5,
    parameter  int GREEN_MAX  = 11,
    parameter  int YELLOW_CYC = 1,
    parameter  int PED_CYC    = 4,
    localparam int IDX_W      = $clog2(NUM_ROADS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ROADS-1:0] sensor,
`ifdef TRAFFIC_PED_EN
    input  logic                 ped_req,
    output logic                 ped_walk,
`endif
    output logic [NUM_ROADS-1:0] red,
    output logic [NUM_ROADS-1:0] yellow,
    output logic [NUM_ROADS-1:0] green,
    output logic [IDX_W-1:0]     active_road,
    output logic [1:0]           phase
);

    localparam int CNT_W = $clog2(GREEN_MAX + 1);

    localparam logic [1:0] ST_GREEN   = GREEN;
    localparam logic [1:0] ST_YELLOW  = YELLOW;
`ifdef TRAFFIC_PED_EN
    localparam logic [1:0] ST_ALL_RED = ALL_RED;
    localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_CYC - 1);
`endif

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(GREEN_MAX);

    generate
        if (NUM_ROADS < 2) begin : g_chk_roads
            $error("traffic_ctrl_nroad: NUM_ROADS must be >= 2");
        end
        if (GREEN_MIN < 1) begin : g_chk_gmin
            $error("traffic_ctrl_nroad: GREEN_MIN must be >= 1");
        end
        if (GREEN_MAX < GREEN_MIN) begin : g_chk_gmax
            $error("traffic_ctrl_nroad: GREEN_MAX must be >= GREEN_MIN");
        end
        // The phase counter saturates at GREEN_MAX, so every timed phase must fit under it.
        if (YELLOW_CYC < 1 || YELLOW_CYC > GREEN_MAX + 1) begin : g_chk_yel
            $error("traffic_ctrl_nroad: YELLOW_CYC must be in 1..GREEN_MAX+1");
        end
        if (PED_CYC < 1 || PED_CYC > GREEN_MAX + 1) begin : g_chk_ped
            $error("traffic_ctrl_nroad: PED_CYC must be in 1..GREEN_MAX+1");
        end
    endgenerate

    logic [1:0]           phase_reg,  phase_next;
    logic [IDX_W-1:0]     road_reg,   road_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]     cnt_reg,    cnt_next;
    logic [NUM_ROADS-1:0] green_next, yellow_next, red_next;
    logic [NUM_ROADS-1:0] road_mask;
    logic                 other_req, cross_req, grant_go;
    logic [IDX_W-1:0]     arb_grant;
    logic                 arb_valid;
`ifdef TRAFFIC_PED_EN
    logic                 ped_pend_reg, ped_pend_next;
    logic                 ped_extra;
    assign ped_extra = ped_pend_reg;
`else
    logic                 ped_extra;
    assign ped_extra = 1'b0;
`endif

    rr_arbiter #(
        .NUM_ROADS(NUM_ROADS)
    ) u_arb (
        .req   (sensor[NUM_ROADS-1:1]),
        .rr_ptr(rr_ptr_reg),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // cross_req: cars on non-priority roads other than the one currently served.
    assign road_mask = NUM_ROADS'(1) << road_reg;
    assign other_req = (|sensor[NUM_ROADS-1:1]) | ped_extra;
    assign cross_req = (|(sensor & ~road_mask & ~NUM_ROADS'(1))) | ped_extra;

    always_comb begin
        phase_next  = phase_reg;
        road_next   = road_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_go    = 1'b0;
        case (phase_reg)
            ST_GREEN: begin
                if (road_reg == '0) begin
                    if (other_req && cnt_reg >= MIN_LAST) phase_next = ST_YELLOW;
                end else if (cnt_reg >= MIN_LAST && sensor[road_reg] == NO_CARS) begin
                    phase_next = ST_YELLOW;
                end else if (cnt_reg >= MAX_LAST && (sensor[0] == CARS || cross_req)) begin
                    phase_next = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (cnt_reg >= YEL_LAST) begin
`ifdef TRAFFIC_PED_EN
                    if (ped_pend_reg) phase_next = ST_ALL_RED;
                    else              grant_go   = 1'b1;
`else
                    grant_go = 1'b1;
`endif
                end
            end
`ifdef TRAFFIC_PED_EN
            ST_ALL_RED: begin
                if (cnt_reg >= PED_LAST) grant_go = 1'b1;
            end
`endif
            default: begin
                phase_next = ST_GREEN;
                road_next  = '0;
            end
        endcase
        if (grant_go) begin
            phase_next = ST_GREEN;
            if (sensor[0] == CARS || !arb_valid) begin
                road_next = '0;
            end else begin
                road_next   = arb_grant;
                rr_ptr_next = arb_grant;
            end
        end
    end

    assign cnt_next = (phase_next != phase_reg) ? '0 :
                      (cnt_reg == CNT_SAT)      ? cnt_reg : cnt_reg + 1'b1;

`ifdef TRAFFIC_PED_EN
    // Entry into ALL_RED consumes the request; a request seen during the walk re-arms it.
    assign ped_pend_next = (phase_next == ST_ALL_RED && phase_reg != ST_ALL_RED) ? 1'b0
                         : (ped_pend_reg | ped_req);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROADS; gi++) begin : g_lamp
            assign green_next[gi]  = (phase_next == ST_GREEN)  && (road_next == IDX_W'(gi));
            assign yellow_next[gi] = (phase_next == ST_YELLOW) && (road_next == IDX_W'(gi));
        end
    endgenerate
    assign red_next = ~(green_next | yellow_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg  <= ST_GREEN;
            road_reg   <= '0;
            rr_ptr_reg <= IDX_W'(NUM_ROADS - 1);
            cnt_reg    <= '0;
            green      <= NUM_ROADS'(1);
            yellow     <= '0;
            red        <= ~NUM_ROADS'(1);
`ifdef TRAFFIC_PED_EN
            ped_pend_reg <= 1'b0;
            ped_walk     <= 1'b0;
`endif
        end else begin
            phase_reg  <= phase_next;
            road_reg   <= road_next;
            rr_ptr_reg <= rr_ptr_next;
            cnt_reg    <= cnt_next;
            green      <= green_next;
            yellow     <= yellow_next;
            red        <= red_next;
`ifdef TRAFFIC_PED_EN
            ped_pend_reg <= ped_pend_next;
            ped_walk     <= (phase_next == ST_ALL_RED);
`endif
        end
    end

    assign active_road = road_reg;
    assign phase       = phase_reg;

endmodule

// File: tb/tb_traffic_ctrl_nroad.sv
// Directed bench for traffic_ctrl_nroad at NUM_ROADS=4 with default timings:
// table-driven cycle vectors plus hand-written reset, idle and fairness sequences.
module tb_traffic_ctrl_nroad;
    import shared_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sensor;
    logic [3:0] red, yellow, green;
    logic [1:0] active_road;
    logic [1:0] phase;
`ifdef TRAFFIC_PED_EN
    logic       ped_req;
    logic       ped_walk;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    traffic_ctrl_nroad #(
        .NUM_ROADS (4),
        .GREEN_MIN (5),
        .GREEN_MAX (11),
        .YELLOW_CYC(1),
        .PED_CYC   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor     (sensor),
`ifdef TRAFFIC_PED_EN
        .ped_req    (ped_req),
        .ped_walk   (ped_walk),
`endif
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .active_road(active_road),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sensor;
        logic [3:0] g;
        logic [3:0] y;
        logic [1:0] road;
        logic [1:0] ph;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] s, input logic [3:0] g, input logic [3:0] y,
                                input logic [1:0] r, input logic [1:0] ph, input int reps);
        vec_t v;
        v.sensor = s; v.g = g; v.y = y; v.road = r; v.ph = ph;
        for (int i = 0; i < reps; i++) tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lamps(input string name);
        logic ok;
        ok = ((red ^ yellow ^ green) == 4'b1111) &&
             (((red & yellow) | (red & green) | (yellow & green)) == 4'b0000);
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_green"},  {28'd0, green},  32'h1);
        chk({tag, "_red"},    {28'd0, red},    32'he);
        chk({tag, "_yellow"}, {28'd0, yellow}, 32'h0);
        chk({tag, "_phase"},  {30'd0, phase},  32'(GREEN));
        chk({tag, "_road"},   {30'd0, active_road}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int runs_road[$];
        int runs_len[$];
        int cur_len;
        int cur_road;
        bit in_run;
        int exp_road[5];
        int exp_len[5];

        rst    = 1'b1;
        sensor = 4'b0100;
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b0;
`endif
        #1;
        chk_reset_state("por");
        do_reset();
        chk_reset_state("reset");

        // Road 0 yields after its minimum green, road 2 is held alone, then
        // yields to road 0 once past GREEN_MAX; road 0 is re-granted, then road 2
        // is reached by wrap and released after its minimum green.
        add(4'b0100, 4'b0001, 4'b0000, 2'd0, GREEN,  4);
        add(4'b0100, 4'b0000, 4'b0001, 2'd0, YELLOW, 1);
        add(4'b0100, 4'b0100, 4'b0000, 2'd2, GREEN,  16);
        add(4'b0101, 4'b0000, 4'b0100, 2'd2, YELLOW, 1);
        add(4'b0101, 4'b0001, 4'b0000, 2'd0, GREEN,  5);
        add(4'b0101, 4'b0000, 4'b0001, 2'd0, YELLOW, 1);
        add(4'b0100, 4'b0100, 4'b0000, 2'd2, GREEN,  1);
        add(4'b0000, 4'b0100, 4'b0000, 2'd2, GREEN,  4);
        add(4'b0000, 4'b0000, 4'b0100, 2'd2, YELLOW, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            sensor = tbl[i].sensor;
            step();
            $display("vec %0d sensor=%b green=%b yellow=%b red=%b road=%0d phase=%0d",
                     i, sensor, green, yellow, red, active_road, phase);
            chk($sformatf("vec%0d_green", i),  {28'd0, green},  {28'd0, tbl[i].g});
            chk($sformatf("vec%0d_yellow", i), {28'd0, yellow}, {28'd0, tbl[i].y});
            chk($sformatf("vec%0d_red", i),    {28'd0, red},    {28'd0, ~(tbl[i].g | tbl[i].y)});
            chk($sformatf("vec%0d_road", i),   {30'd0, active_road}, {30'd0, tbl[i].road});
            chk($sformatf("vec%0d_phase", i),  {30'd0, phase},  {30'd0, tbl[i].ph});
        end

        // Asynchronous reset while road 2 is yellow: lamps return before any edge.
        #2;
        rst = 1'b1;
        #1;
        $display("async reset mid-yellow: green=%b yellow=%b red=%b", green, yellow, red);
        chk_reset_state("async_rst");
        step();
        chk_reset_state("rst_held");
        rst = 1'b0;

        // Idle junction: road 0 stays green for 100 cycles.
        sensor = 4'b0000;
        for (int k = 0; k < 100; k++) begin
            step();
            chk("idle_green", {28'd0, green}, 32'h1);
            chk("idle_yellow", {28'd0, yellow}, 32'h0);
        end
        $display("idle run: 100 cycles, green=%b", green);

        // Continuous demand on roads 1 and 3: alternate with full GREEN_MAX slices.
        do_reset();
        sensor   = 4'b1010;
        in_run   = 1'b0;
        cur_len  = 0;
        cur_road = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            chk_lamps("fair_lamps");
            if (green != 4'b0000) begin
                if (!in_run) begin
                    in_run   = 1'b1;
                    cur_road = int'(active_road);
                    cur_len  = 0;
                end
                cur_len++;
            end else if (in_run) begin
                in_run = 1'b0;
                runs_road.push_back(cur_road);
                runs_len.push_back(cur_len);
                $display("green run: road=%0d cycles=%0d", cur_road, cur_len);
            end
        end
        exp_road = '{0, 1, 3, 1, 3};
        exp_len  = '{4, 11, 11, 11, 11};
        chk("fair_run_count", 32'(runs_road.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < runs_road.size()) begin
                chk($sformatf("fair_run%0d_road", i), 32'(runs_road[i]), 32'(exp_road[i]));
                chk($sformatf("fair_run%0d_len", i),  32'(runs_len[i]),  32'(exp_len[i]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
